// File: rtl/cmd_dispatcher_pkg.sv
// rtl/cmd_dispatcher_pkg.sv - shared command type and dispatcher state encoding
package cmd_dispatcher_pkg;

  // Command word as stored in cmd_queue and broadcast to the PEs
  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  arg;
    logic [15:0] addr;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    FETCH = 2'd2,
    ISSUE = 2'd3
  } dispatch_state_t;

endpackage

// File: rtl/cmd_dispatcher_picker.sv
// rtl/cmd_dispatcher_picker.sv - combinational round-robin search for a free PE
module rr_free_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     busy,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] sel,
  output logic             any_free
);

  // Scan from the farthest offset back to ptr so the nearest free PE wins
  always_comb begin
    int idx;
    sel      = '0;
    any_free = 1'b0;
    idx      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (!busy[idx]) begin
        sel      = IDX_W'(idx);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmd_dispatcher.sv
// rtl/cmd_dispatcher.sv - pops cmd_queue and hands commands round-robin to idle PEs
module cmd_dispatcher
  import cmd_dispatcher_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_enable,
  input  logic                     i_fifo_empty,
  output logic                     o_fifo_read,
  input  logic [$bits(cmd_t)-1:0]  i_fifo_data,
  output logic [NUM_PE-1:0]        o_pe_valid,
  output logic [$bits(cmd_t)-1:0]  o_pe_cmd,
  input  logic [NUM_PE-1:0]        i_pe_ready,
  input  logic [NUM_PE-1:0]        i_pe_done,
  output logic [NUM_PE-1:0]        o_pe_busy,
  output logic                     o_idle,
  output logic [CNT_W-1:0]         o_issued_count
);

  localparam int IDX_W = $clog2(NUM_PE);
  localparam int CMD_W = $bits(cmd_t);

  dispatch_state_t   state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [NUM_PE-1:0] busy_q, busy_d;
  logic [CMD_W-1:0]  cmd_reg_q, cmd_reg_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [IDX_W-1:0]  pick_sel;
  logic              pick_any;
  logic [NUM_PE-1:0] sel_onehot;
  logic              handshake;

  rr_free_picker #(
    .N     (NUM_PE),
    .IDX_W (IDX_W)
  ) u_picker (
    .busy     (busy_q),
    .ptr      (rr_ptr_q),
    .sel      (pick_sel),
    .any_free (pick_any)
  );

  assign sel_onehot = NUM_PE'(1) << sel_q;
  assign handshake  = (state_q == ISSUE) && i_pe_ready[sel_q];

  // Next-state, busy tracking and counters; a handshake set beats a same-cycle done
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    sel_d     = sel_q;
    cmd_reg_d = cmd_reg_q;
    count_d   = count_q;
    busy_d    = busy_q & ~i_pe_done;
    if (handshake) begin
      busy_d = busy_d | sel_onehot;
    end
    case (state_q)
      IDLE: begin
        if (i_enable && !i_fifo_empty && (~busy_q != '0)) begin
          state_d = POP;
        end
      end
      POP: begin
        state_d = FETCH;
      end
      FETCH: begin
        cmd_reg_d = i_fifo_data;
        sel_d     = pick_any ? pick_sel : sel_q;
        state_d   = ISSUE;
      end
      ISSUE: begin
        if (handshake) begin
          rr_ptr_d = (sel_q == IDX_W'(NUM_PE - 1)) ? '0 : sel_q + 1'b1;
          count_d  = count_q + 1'b1;
          state_d  = (i_enable && !i_fifo_empty && (~busy_d != '0)) ? POP : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any command still in flight
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      sel_q     <= '0;
      busy_q    <= '0;
      cmd_reg_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      cmd_reg_q <= cmd_reg_d;
      count_q   <= count_d;
    end
  end

  assign o_fifo_read    = (state_q == POP);
  assign o_pe_valid     = (state_q == ISSUE) ? sel_onehot : '0;
  assign o_pe_cmd       = (state_q == ISSUE) ? cmd_reg_q : '0;
  assign o_pe_busy      = busy_q;
  assign o_idle         = (state_q == IDLE) && (busy_q == '0);
  assign o_issued_count = count_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb/tb_cmd_dispatcher.sv - directed and randomized bench for cmd_dispatcher
module tb_cmd_dispatcher;
  import cmd_dispatcher_pkg::*;

  localparam int NUM_PE = 4;
  localparam int CNT_W  = 2;
  localparam int CW     = $bits(cmd_t);

  logic              i_clk = 1'b0;
  logic              i_rstn = 1'b0;
  logic              i_enable = 1'b0;
  logic              i_fifo_empty = 1'b1;
  logic              o_fifo_read;
  logic [CW-1:0]     i_fifo_data = '0;
  logic [NUM_PE-1:0] o_pe_valid;
  logic [CW-1:0]     o_pe_cmd;
  logic [NUM_PE-1:0] i_pe_ready = '0;
  logic [NUM_PE-1:0] i_pe_done = '0;
  logic [NUM_PE-1:0] o_pe_busy;
  logic              o_idle;
  logic [CNT_W-1:0]  o_issued_count;

  cmd_dispatcher #(.NUM_PE(NUM_PE), .CNT_W(CNT_W)) dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_enable       (i_enable),
    .i_fifo_empty   (i_fifo_empty),
    .o_fifo_read    (o_fifo_read),
    .i_fifo_data    (i_fifo_data),
    .o_pe_valid     (o_pe_valid),
    .o_pe_cmd       (o_pe_cmd),
    .i_pe_ready     (i_pe_ready),
    .i_pe_done      (i_pe_done),
    .o_pe_busy      (o_pe_busy),
    .o_idle         (o_idle),
    .o_issued_count (o_issued_count)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_reads = 0;

  logic [CW-1:0] fifo[$];

  // Reference: where the in-flight command is (0 none, 1 popping, 2 fetching, 3 offered)
  int                m_phase;
  int                m_ptr;
  int                m_sel;
  int                m_cnt;
  bit [NUM_PE-1:0]   m_busy;
  logic [CW-1:0]     m_cmd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int first_free(input bit [NUM_PE-1:0] busy, input int ptr);
    for (int k = 0; k < NUM_PE; k++) begin
      if (!busy[(ptr + k) % NUM_PE]) return (ptr + k) % NUM_PE;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_sel = 0; m_cnt = 0; m_busy = '0; m_cmd = '0;
  endtask

  // Apply the dispatch rules to the inputs that the coming clock edge will see
  task automatic model_advance();
    bit [NUM_PE-1:0] nb;
    if (!i_rstn) begin
      model_reset();
      return;
    end
    nb = m_busy & ~i_pe_done;
    case (m_phase)
      0: if (i_enable && !i_fifo_empty && first_free(m_busy, 0) >= 0) m_phase = 1;
      1: m_phase = 2;
      2: begin
        m_cmd   = i_fifo_data;
        m_sel   = first_free(m_busy, m_ptr);
        m_phase = 3;
      end
      default: begin
        if (i_pe_ready[m_sel]) begin
          nb[m_sel] = 1'b1;
          m_ptr     = (m_sel + 1) % NUM_PE;
          m_cnt     = (m_cnt + 1) % (1 << CNT_W);
          m_phase   = (i_enable && !i_fifo_empty && first_free(nb, 0) >= 0) ? 1 : 0;
        end
      end
    endcase
    m_busy = nb;
  endtask

  task automatic check_model();
    chk("fifo_read", 64'(o_fifo_read), 64'(m_phase == 1));
    chk("pe_valid", 64'(o_pe_valid), (m_phase == 3) ? 64'(1) << m_sel : 64'd0);
    chk("pe_cmd", 64'(o_pe_cmd), (m_phase == 3) ? 64'(m_cmd) : 64'd0);
    chk("pe_busy", 64'(o_pe_busy), 64'(m_busy));
    chk("idle", 64'(o_idle), 64'(m_phase == 0 && m_busy == '0));
    chk("count", 64'(o_issued_count), 64'(m_cnt));
  endtask

  // cmd_queue behaviour: a pop delivers the head on the following cycle
  task automatic fifo_env();
    if (o_fifo_read === 1'b1) begin
      n_reads++;
      if (fifo.size() == 0) begin
        chk("pop_while_empty", 64'd1, 64'd0);
      end else begin
        i_fifo_data = fifo.pop_front();
      end
    end
    i_fifo_empty = (fifo.size() == 0);
  endtask

  task automatic push(input logic [CW-1:0] c);
    fifo.push_back(c);
    i_fifo_empty = 1'b0;
  endtask

  task automatic cycle();
    model_advance();
    @(negedge i_clk);
    check_model();
    fifo_env();
  endtask

  task automatic do_reset();
    i_rstn = 1'b0; i_enable = 1'b0; i_pe_ready = '0; i_pe_done = '0;
    fifo.delete(); i_fifo_empty = 1'b1; i_fifo_data = '0;
    cycle(); cycle();
    i_rstn = 1'b1;
    n_reads = 0;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (o_pe_valid == '0 && n < budget) begin
      cycle();
      n++;
    end
    if (o_pe_valid == '0) chk("wait_valid_timeout", 64'd1, 64'd0);
  endtask

  logic [NUM_PE-1:0] seen[$];
  logic [NUM_PE-1:0] hold_v;
  logic [CW-1:0]     hold_c;
  int                max_cnt;

  initial begin
    model_reset();
    @(negedge i_clk);

    // Reset held with a non-empty queue and enable high
    push(32'h1111_2222); push(32'h3333_4444);
    i_enable = 1'b1; i_pe_ready = '1;
    cycle(); cycle(); cycle();
    chk("rst_fifo_read", 64'(o_fifo_read), 64'd0);
    chk("rst_pe_valid", 64'(o_pe_valid), 64'd0);
    chk("rst_pe_cmd", 64'(o_pe_cmd), 64'd0);
    chk("rst_busy", 64'(o_pe_busy), 64'd0);
    chk("rst_count", 64'(o_issued_count), 64'd0);
    chk("rst_idle", 64'(o_idle), 64'd1);
    do_reset();

    // Single command: pop at T, offer to PE0 at T+2
    i_pe_ready = '1;
    push(32'hA5A5_0001);
    i_enable = 1'b1;
    cycle();
    chk("t2_read_T", 64'(o_fifo_read), 64'd1);
    cycle();
    chk("t2_read_T1", 64'(o_fifo_read), 64'd0);
    chk("t2_valid_T1", 64'(o_pe_valid), 64'd0);
    cycle();
    chk("t2_valid_T2", 64'(o_pe_valid), 64'b0001);
    chk("t2_cmd_T2", 64'(o_pe_cmd), 64'hA5A5_0001);
    cycle();
    chk("t2_busy", 64'(o_pe_busy), 64'b0001);
    chk("t2_count", 64'(o_issued_count), 64'd1);
    chk("t2_valid_after", 64'(o_pe_valid), 64'd0);
    push(32'hA5A5_0002);
    wait_valid(10);
    chk("t2_rr_next_pe1", 64'(o_pe_valid), 64'b0010);
    do_reset();

    // Six commands, no completions: PE0..PE3 then stall; done on PE2 frees it
    i_pe_ready = '1;
    for (int k = 0; k < 6; k++) push(CW'(32'hC000_0000 + k));
    i_enable = 1'b1;
    seen.delete();
    for (int n = 0; n < 30; n++) begin
      cycle();
      if (o_pe_valid != '0) seen.push_back(o_pe_valid);
    end
    chk("t3_issues", 64'(seen.size()), 64'd4);
    for (int k = 0; k < 4 && k < seen.size(); k++) chk("t3_order", 64'(seen[k]), 64'(1) << k);
    chk("t3_fifo_left", 64'(fifo.size()), 64'd2);
    chk("t3_reads", 64'(n_reads), 64'd4);
    chk("t3_busy_all", 64'(o_pe_busy), 64'hF);
    i_pe_done = 4'b0100;
    cycle();
    i_pe_done = '0;
    wait_valid(10);
    chk("t3_to_pe2", 64'(o_pe_valid), 64'b0100);
    chk("t3_pe2_cmd", 64'(o_pe_cmd), 64'hC000_0004);
    cycle();
    do_reset();

    // Backpressure on PE0 for five cycles
    i_pe_ready = 4'b1110;
    push(32'hBEEF_0000); push(32'hBEEF_0001);
    i_enable = 1'b1;
    wait_valid(10);
    hold_v = o_pe_valid; hold_c = o_pe_cmd;
    chk("t4_first_pe0", 64'(hold_v), 64'b0001);
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk("t4_valid_stable", 64'(o_pe_valid), 64'(hold_v));
      chk("t4_cmd_stable", 64'(o_pe_cmd), 64'(hold_c));
      chk("t4_no_pop", 64'(o_fifo_read), 64'd0);
      chk("t4_count_hold", 64'(o_issued_count), 64'd0);
    end
    i_pe_ready = '1;
    cycle();
    chk("t4_count_after", 64'(o_issued_count), 64'd1);
    do_reset();

    // Enable drops while fetching: command still goes out, then no new pop
    i_pe_ready = '1;
    push(32'hE0E0_0001); push(32'hE0E0_0002);
    i_enable = 1'b1;
    cycle(); cycle();
    i_enable = 1'b0;
    cycle();
    chk("t5_issued", 64'(o_pe_valid), 64'b0001);
    for (int n = 0; n < 6; n++) cycle();
    chk("t5_count", 64'(o_issued_count), 64'd1);
    chk("t5_reads", 64'(n_reads), 64'd1);
    chk("t5_fifo_left", 64'(fifo.size()), 64'd1);
    chk("t5_not_idle_busy", 64'(o_idle), 64'd0);
    do_reset();

    // Reset asserted while offering the second command
    push(32'hD0D0_0001); push(32'hD0D0_0002);
    i_enable = 1'b1;
    cycle(); cycle(); cycle();
    i_pe_ready = '1;
    cycle();
    i_pe_ready = '0;
    cycle(); cycle();
    chk("t6_in_issue", 64'(o_pe_valid), 64'b0010);
    chk("t6_count_pre", 64'(o_issued_count), 64'd1);
    i_rstn = 1'b0;
    #1;
    model_reset();
    chk("t6_valid_now", 64'(o_pe_valid), 64'd0);
    chk("t6_count_now", 64'(o_issued_count), 64'd0);
    chk("t6_busy_now", 64'(o_pe_busy), 64'd0);
    do_reset();

    // Counter wrap with a 2-bit counter
    i_pe_ready = '1;
    for (int k = 0; k < 4; k++) push(CW'(32'hF000_0000 + k));
    i_enable = 1'b1;
    max_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (int'(o_issued_count) > max_cnt) max_cnt = int'(o_issued_count);
    end
    chk("wrap_max", 64'(max_cnt), 64'd3);
    chk("wrap_zero", 64'(o_issued_count), 64'd0);
    chk("wrap_busy", 64'(o_pe_busy), 64'hF);
    do_reset();

    // Randomized traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0 && fifo.size() < 8) push(CW'($urandom));
      i_enable   = ($urandom_range(7) != 0);
      i_pe_ready = NUM_PE'($urandom) | NUM_PE'($urandom);
      i_pe_done  = NUM_PE'($urandom) & NUM_PE'($urandom) & NUM_PE'($urandom);
      i_rstn     = ($urandom_range(499) != 0);
      cycle();
      if (!i_rstn) begin
        i_rstn = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
